tcu_drl_mask_expand: RTL and testbench

// - Inverse of the DRL lane-mask reduction: turns per-lane validity back into an element-level valid mask.
// - Collects BEATS consecutive TCK-bit lane masks, one per k-step, over a valid/ready handshake.
// - Expands each beat per TCU format and emits one concatenated BEATS*TCU_MAX_INPUTS element mask.
// - Sits between the DRL dot-product lanes and the TCU writeback/result-merge stage.

---
 rtl/tcu_drl_mask_expand.sv | 162 ++++++++++++++++
 tb/tb_tcu_drl_mask_expand.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcu_drl_mask_expand.sv
// Expands BEATS lane-mask beats into one concatenated element-level valid mask for TCU writeback.
// Optional build macro TCU_DRL_MASK_CHECK_EN adds illegal-format / illegal-FP32-lane error detection.
module tcu_drl_mask_expand #(
  parameter int unsigned N              = 2,
  parameter int unsigned TCK            = 2 * N,
  parameter int unsigned TCU_MAX_INPUTS = 4 * TCK,
  parameter int unsigned BEATS          = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [TCK-1:0]                    in_lane_mask,
  input  logic [3:0]                        in_fmt,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BEATS*TCU_MAX_INPUTS-1:0]   out_vld_mask,
  output logic [3:0]                        out_fmt,
  output logic                              out_err
);

  localparam int unsigned M     = TCU_MAX_INPUTS;
  localparam int unsigned OUT_W = BEATS * M;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [3:0] TCU_FP32_ID = 4'd0;
  localparam logic [3:0] TCU_FP16_ID = 4'd1;
  localparam logic [3:0] TCU_BF16_ID = 4'd2;
  localparam logic [3:0] TCU_FP8_ID  = 4'd3;
  localparam logic [3:0] TCU_BF8_ID  = 4'd4;
  localparam logic [3:0] TCU_I8_ID   = 4'd5;
  localparam logic [3:0] TCU_U8_ID   = 4'd6;
  localparam logic [3:0] TCU_I4_ID   = 4'd7;
  localparam logic [3:0] TCU_U4_ID   = 4'd8;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [OUT_W-1:0]   vld_mask_q, vld_mask_d;
  logic [3:0]         fmt_q, fmt_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [4*TCK-1:0]   exp_fp32_c;
  logic [4*TCK-1:0]   exp_fp16_c;
  logic [2*TCK-1:0]   exp_fp8_c;
  logic [M-1:0]       slice_c;
  logic [OUT_W-1:0]   wr_bits_c;
  logic               beat_err_c;
`ifdef TCU_DRL_MASK_CHECK_EN
  logic [TCK-1:0]     odd_lanes_c;
`endif

  // Per-format lane replication; FP32 spans two lane slots so only even lanes drive it.
  for (genvar i = 0; i < TCK; i++) begin : g_lane
    assign exp_fp16_c[4*i +: 4] = {4{in_lane_mask[i]}};
    assign exp_fp8_c[2*i +: 2]  = {2{in_lane_mask[i]}};
    if (i % 2 == 0) begin : g_even
      assign exp_fp32_c[4*i +: 8] = {8{in_lane_mask[i]}};
    end
`ifdef TCU_DRL_MASK_CHECK_EN
    assign odd_lanes_c[i] = (i % 2 == 1) ? in_lane_mask[i] : 1'b0;
`endif
  end

  // One-hot slice write enable for the beat currently being collected.
  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    assign wr_bits_c[b*M +: M] = {M{beat_cnt_q == CNT_W'(b)}};
  end

  always_comb begin
    slice_c = '0;
    case (in_fmt)
      TCU_FP32_ID:                                     slice_c = M'(exp_fp32_c);
      TCU_FP16_ID, TCU_BF16_ID:                        slice_c = M'(exp_fp16_c);
      TCU_FP8_ID, TCU_BF8_ID, TCU_I8_ID, TCU_U8_ID:    slice_c = M'(exp_fp8_c);
      TCU_I4_ID, TCU_U4_ID:                            slice_c = M'(in_lane_mask);
      default:                                         slice_c = '0;
    endcase
  end

`ifdef TCU_DRL_MASK_CHECK_EN
  always_comb begin
    beat_err_c = (in_fmt > TCU_U4_ID) ||
                 ((in_fmt == TCU_FP32_ID) && (odd_lanes_c != '0));
  end
`else
  assign beat_err_c = 1'b0;
`endif

  // Next-state: collect beats into slices, then hold the group until consumed.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    vld_mask_d = vld_mask_q;
    fmt_d      = fmt_q;
    err_d      = err_q;
    case (state_q)
      S_COLLECT: begin
        if (in_valid) begin
          vld_mask_d = (vld_mask_q & ~wr_bits_c) | ({BEATS{slice_c}} & wr_bits_c);
          if (beat_cnt_q == '0) begin
            fmt_d = in_fmt;
          end else if (in_fmt != fmt_q) begin
            err_d = 1'b1;
          end
          if (beat_err_c) begin
            err_d = 1'b1;
          end
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            state_d    = S_HOLD;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d    = S_COLLECT;
          vld_mask_d = '0;
          err_d      = 1'b0;
        end
      end
      default: state_d = S_COLLECT;
    endcase
    in_ready_d  = (state_d == S_COLLECT);
    out_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_COLLECT;
      beat_cnt_q  <= '0;
      vld_mask_q  <= '0;
      fmt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      vld_mask_q  <= vld_mask_d;
      fmt_q       <= fmt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_vld_mask = vld_mask_q;
  assign out_fmt      = fmt_q;
  assign out_err      = err_q;

endmodule

// File: tb/tb_tcu_drl_mask_expand.sv
// Bench for tcu_drl_mask_expand: a BEATS=1 and a BEATS=4 instance checked against a group-level model.
module tb_tcu_drl_mask_expand;

  localparam logic [3:0] FP32 = 4'd0, FP16 = 4'd1, BF16 = 4'd2, FP8 = 4'd3, BF8 = 4'd4;
  localparam logic [3:0] I8 = 4'd5, U8 = 4'd6, I4 = 4'd7, U4 = 4'd8;
`ifdef TCU_DRL_MASK_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        iv  [2];
  logic [3:0]  il  [2];
  logic [3:0]  ifm [2];
  logic        orr [2];
  logic        ir  [2];
  logic        ov  [2];
  logic        oe  [2];
  logic [3:0]  of  [2];
  logic [15:0] om1;
  logic [63:0] om4;

  always #5 clk = ~clk;

  tcu_drl_mask_expand #(.N(2), .TCK(4), .TCU_MAX_INPUTS(16), .BEATS(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_lane_mask(il[0]),
    .in_fmt(ifm[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_vld_mask(om1),
    .out_fmt(of[0]), .out_err(oe[0]));

  tcu_drl_mask_expand #(.N(2), .TCK(4), .TCU_MAX_INPUTS(16), .BEATS(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_lane_mask(il[1]),
    .in_fmt(ifm[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_vld_mask(om4),
    .out_fmt(of[1]), .out_err(oe[1]));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake did not complete within budget at %0t", name, $time);
  endtask

  function automatic int beats_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [63:0] om_of(input int d);
    return (d == 0) ? 64'(om1) : om4;
  endfunction

  // Element e is valid when the lane that owns it (per format) is set.
  function automatic logic [15:0] ref_slice(input logic [3:0] m, input logic [3:0] f);
    logic [15:0] r;
    int lane;
    r = '0;
    for (int e = 0; e < 16; e++) begin
      case (f)
        FP32:               lane = (e / 8) * 2;
        FP16, BF16:         lane = e / 4;
        FP8, BF8, I8, U8:   lane = e / 2;
        I4, U4:             lane = e;
        default:            lane = 99;
      endcase
      if (lane < 4 && ((m >> lane) & 4'd1) != 4'd0) r = r | (16'(1) << e);
    end
    return r;
  endfunction

  function automatic logic ref_beat_err(input logic [3:0] m, input logic [3:0] f);
    return CHK_EN && ((f > U4) || (f == FP32 && (m & 4'b1010) != 4'd0));
  endfunction

  typedef struct packed { logic [3:0] m; logic [3:0] f; } beat_t;
  beat_t       gb [2][4];
  int          gc [2];
  logic        pend [2];
  logic [63:0] e_mask [2];
  logic [3:0]  e_fmt [2];
  logic        e_err [2];

  // Group-level model: gather accepted beats, then publish the whole expected group.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        gc[d]   <= 0;
        pend[d] <= 1'b0;
      end else if (pend[d]) begin
        if (orr[d]) pend[d] <= 1'b0;
      end else if (iv[d]) begin
        beat_t nb;
        beat_t cur;
        logic [63:0] mk;
        logic er;
        logic [3:0] f0;
        nb = '{m: il[d], f: ifm[d]};
        gb[d][gc[d]] <= nb;
        if (gc[d] == beats_of(d) - 1) begin
          mk = '0;
          er = 1'b0;
          f0 = (gc[d] == 0) ? nb.f : gb[d][0].f;
          for (int b = 0; b < beats_of(d); b++) begin
            cur = (b == gc[d]) ? nb : gb[d][b];
            mk = mk | (64'(ref_slice(cur.m, cur.f)) << (16 * b));
            if (cur.f != f0 || ref_beat_err(cur.m, cur.f)) er = 1'b1;
          end
          e_mask[d] <= mk;
          e_fmt[d]  <= f0;
          e_err[d]  <= er;
          pend[d]   <= 1'b1;
          gc[d]     <= 0;
        end else begin
          gc[d] <= gc[d] + 1;
        end
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d_in_ready", d), 64'(ir[d]), 64'(!pend[d]));
        check($sformatf("d%0d_out_valid", d), 64'(ov[d]), 64'(pend[d]));
        if (pend[d]) begin
          check($sformatf("d%0d_out_vld_mask", d), om_of(d), e_mask[d]);
          check($sformatf("d%0d_out_fmt", d), 64'(of[d]), 64'(e_fmt[d]));
          check($sformatf("d%0d_out_err", d), 64'(oe[d]), 64'(e_err[d]));
        end
      end
    end
  end

  task automatic send(input int d, input logic [3:0] m, input logic [3:0] f);
    int t;
    t = 0;
    while (!ir[d] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout("send");
    iv[d] = 1'b1; il[d] = m; ifm[d] = f;
    @(negedge clk);
    iv[d] = 1'b0;
  endtask

  task automatic consume(input int d);
    int t;
    t = 0;
    orr[d] = 1'b1;
    while (!ov[d] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout("consume");
    @(negedge clk);
    orr[d] = 1'b0;
  endtask

  logic [3:0]  tv_m [8] = '{4'b0101, 4'b0100, 4'b0011, 4'b1010, 4'b1011, 4'b0101, 4'b1000, 4'b0001};
  logic [3:0]  tv_f [8] = '{FP16,    FP32,    FP32,    I8,      U4,      4'hF,    BF16,    FP8};
  logic [15:0] tv_e [8] = '{16'h0F0F, 16'hFF00, 16'h00FF, 16'h00CC, 16'h000B, 16'h0000, 16'hF000, 16'h0003};
  bit          tv_c [8] = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b0,    1'b1,    1'b0,    1'b0};
  logic [3:0]  cur_fmt [2];

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; il[d] = '0; ifm[d] = '0; orr[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", 64'(ir[d]), 64'd1);
      check("rst_out_valid", 64'(ov[d]), 64'd0);
      check("rst_out_fmt", 64'(of[d]), 64'd0);
      check("rst_out_err", 64'(oe[d]), 64'd0);
    end
    check("rst_mask1", 64'(om1), 64'd0);
    check("rst_mask4", om4, 64'd0);
    reset = 1'b0;
    chk_on = 1'b1;

    // Single-beat expansion table.
    for (int k = 0; k < 8; k++) begin
      check($sformatf("model_pin%0d", k), 64'(ref_slice(tv_m[k], tv_f[k])), 64'(tv_e[k]));
      send(0, tv_m[k], tv_f[k]);
      check($sformatf("lit_valid%0d", k), 64'(ov[0]), 64'd1);
      check($sformatf("lit_mask%0d", k), 64'(om1), 64'(tv_e[k]));
      check($sformatf("lit_fmt%0d", k), 64'(of[0]), 64'(tv_f[k]));
      check($sformatf("lit_err%0d", k), 64'(oe[0]), 64'(CHK_EN && tv_c[k]));
      consume(0);
    end

    // Backpressure: outputs stable while out_ready is low.
    send(0, 4'b0001, FP16);
    repeat (5) begin
      @(negedge clk);
      check("hold_mask", 64'(om1), 64'h000F);
      check("hold_in_ready", 64'(ir[0]), 64'd0);
    end
    orr[0] = 1'b1;
    @(negedge clk);
    orr[0] = 1'b0;
    check("release_in_ready", 64'(ir[0]), 64'd1);
    check("release_out_valid", 64'(ov[0]), 64'd0);

    // Four-beat group, clean and with a format mismatch.
    send(1, 4'b0001, FP16); send(1, 4'b0010, FP16); send(1, 4'b0100, FP16); send(1, 4'b1000, FP16);
    check("grp_mask", om4, 64'hF000_0F00_00F0_000F);
    check("grp_fmt", 64'(of[1]), 64'(FP16));
    check("grp_err", 64'(oe[1]), 64'd0);
    consume(1);
    send(1, 4'b0001, FP16); send(1, 4'b0010, FP16); send(1, 4'b0100, BF8); send(1, 4'b1000, FP16);
    check("mis_mask", om4, 64'hF000_0030_00F0_000F);
    check("mis_err", 64'(oe[1]), 64'd1);
    consume(1);

    // Reset mid-collection discards the partial group.
    send(1, 4'hF, FP32); send(1, 4'hF, FP32);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_drop_valid", 64'(ov[1]), 64'd0);
    end
    send(1, 4'b0001, FP16); send(1, 4'b0010, FP16); send(1, 4'b0100, FP16); send(1, 4'b1000, FP16);
    check("post_rst_mask", om4, 64'hF000_0F00_00F0_000F);
    check("post_rst_err", 64'(oe[1]), 64'd0);
    consume(1);

    // Randomized traffic on both instances.
    cur_fmt[0] = FP16;
    cur_fmt[1] = FP16;
    repeat (3000) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 15) == 0) cur_fmt[d] = 4'($urandom_range(0, 8));
        iv[d]  = ($urandom_range(0, 3) != 0);
        il[d]  = 4'($urandom);
        ifm[d] = ($urandom_range(0, 9) < 8) ? cur_fmt[d] : 4'($urandom_range(0, 15));
        orr[d] = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; orr[d] = 1'b1;
    end
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
